// File: rtl/instr_mem_loader.sv
// instr_mem_loader: byte-serial program loader into a DEPTH-word instruction memory with a registered read port
// Ports: clk/reset (sync, active-high); start/word_count begin a load; byte_in/byte_valid/byte_ready host byte stream;
// rd_addr/rd_data fetch read (1-cycle latency, 0 out of range); loading/load_done/words_loaded/err status.
module instr_mem_loader #(
  parameter int DEPTH = 11,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] word_count,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  output logic          byte_ready,
  input  logic [31:0]   rd_addr,
  output logic [31:0]   rd_data,
  output logic          loading,
  output logic          load_done,
  output logic [AW-1:0] words_loaded,
  output logic          err
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  localparam logic [AW-1:0] DMAX = AW'(DEPTH);
  state_t state, next;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] count, wl_next;
  logic [1:0] byte_idx;
  logic [23:0] partial;
  logic ok, accept, take, last;
  assign ok = word_count != '0 && word_count <= DMAX;
  assign accept = start && state != LOAD;
  assign take = state == LOAD && byte_valid;
  assign last = take && byte_idx == 2'd3;
  assign wl_next = words_loaded + 1'b1;
  assign byte_ready = state == LOAD;
  assign loading = state == LOAD;
  assign load_done = state == DONE;
  always_comb begin
    next = state;
    if (state != LOAD) next = (start && ok) ? LOAD : state;
    else next = (last && wl_next == count) ? DONE : LOAD;
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_data <= '0;
      count <= '0;
      words_loaded <= '0;
      byte_idx <= '0;
      partial <= '0;
      err <= 1'b0;
    end else begin
      rd_data <= (rd_addr < 32'(DEPTH)) ? mem[rd_addr[AW-1:0]] : '0;
      if (accept && ok) begin
        count <= word_count;
        words_loaded <= '0;
        byte_idx <= '0;
        err <= 1'b0;
      end else if (accept) begin
        err <= 1'b1;
      end
      if (take) begin
        byte_idx <= byte_idx + 1'b1;
        partial <= {partial[15:0], byte_in};
        if (last) begin
          mem[words_loaded] <= {partial, byte_in};
          words_loaded <= wl_next;
        end
      end
    end
  end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: randomized directed bench for instr_mem_loader against a queue-based reference model
module tb_instr_mem_loader;
  localparam int DEPTH = 11;
  localparam int AW = 4;
  logic clk = 0, reset = 0, start = 0, byte_valid = 0;
  logic [AW-1:0] word_count = '0;
  logic [7:0] byte_in = '0;
  logic [31:0] rd_addr = '0;
  logic byte_ready, loading, load_done, err;
  logic [31:0] rd_data;
  logic [AW-1:0] words_loaded;
  int passed = 0, total = 0;
  bit m_load = 0, m_done = 0, m_err = 0;
  int m_cnt = 0, m_wl = 0;
  logic [7:0] q[$];
  logic [31:0] mm [DEPTH];
  logic [31:0] exp_rd = '0;
  logic [31:0] words [DEPTH];

  instr_mem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .loading(loading),
    .load_done(load_done), .words_loaded(words_loaded), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic cycle(input bit rst, input bit st, input int wc, input bit bv,
                       input logic [7:0] b, input logic [31:0] addr);
    reset = rst; start = st; word_count = AW'(wc); byte_valid = bv; byte_in = b; rd_addr = addr;
    exp_rd = (!rst && addr < 32'(DEPTH)) ? mm[addr] : 32'h0;
    if (rst) begin
      m_load = 0; m_done = 0; m_err = 0; m_wl = 0; m_cnt = 0; q.delete();
      foreach (mm[i]) mm[i] = 0;
    end else if (!m_load && st) begin
      if (wc >= 1 && wc <= DEPTH) begin
        m_load = 1; m_done = 0; m_err = 0; m_cnt = wc; m_wl = 0; q.delete();
      end else m_err = 1;
    end else if (m_load && bv) begin
      q.push_back(b);
      if (q.size() == 4) begin
        mm[m_wl] = {q[0], q[1], q[2], q[3]};
        m_wl++;
        q.delete();
        if (m_wl == m_cnt) begin m_load = 0; m_done = 1; end
      end
    end
    @(posedge clk);
    #1;
    start = 0; byte_valid = 0; reset = 0;
    chk("byte_ready", 32'(byte_ready), 32'(m_load));
    chk("loading", 32'(loading), 32'(m_load));
    chk("load_done", 32'(load_done), 32'(m_done));
    chk("err", 32'(err), 32'(m_err));
    chk("words_loaded", 32'(words_loaded), 32'(m_wl));
    chk("rd_data", rd_data, exp_rd);
  endtask

  task automatic send_word(input logic [31:0] w, input logic [31:0] addr, input bit gaps);
    for (int k = 3; k >= 0; k--) begin
      if (gaps) repeat ($urandom_range(0, 2)) cycle(0, 0, 0, 0, 8'($urandom), addr);
      cycle(0, 0, 0, 1, w[k*8 +: 8], addr);
    end
  endtask

  initial begin
    foreach (mm[i]) mm[i] = 0;
    for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
    words[0] = 32'h8C010000;
    words[2] = 32'h24040000;
    words[10] = 32'h14C0FFFD;
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 5, 1, 8'hAA, 0);
    chk("reset_rd_data", rd_data, 32'h0);
    chk("reset_words_loaded", 32'(words_loaded), 32'h0);
    // single word load
    cycle(0, 1, 1, 0, 0, 0);
    send_word(32'h8C010000, 0, 0);
    chk("single_done", 32'(load_done), 32'h1);
    cycle(0, 0, 0, 0, 0, 0);
    chk("single_read", rd_data, 32'h8C010000);
    // illegal counts
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 12, 0, 0, 0);
    chk("bad12_err", 32'(err), 32'h1);
    cycle(0, 1, 0, 1, 8'h11, 0);
    chk("bad0_ready", 32'(byte_ready), 32'h0);
    cycle(0, 1, 15, 0, 0, 0);
    // full load with gaps; rd_addr held at 2 across the word-2 write
    cycle(0, 1, 11, 0, 0, 0);
    chk("err_cleared", 32'(err), 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 3) cycle(0, 1, 2, 0, 0, 2);
      send_word(words[i], (i == 2) ? 32'd2 : 32'($urandom_range(0, 15)), 1);
    end
    chk("full_words_loaded", 32'(words_loaded), 32'd11);
    chk("full_done", 32'(load_done), 32'h1);
    cycle(0, 0, 0, 0, 0, 2);
    chk("collision_new", rd_data, 32'h24040000);
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 0, 0, 0, 32'(i));
    cycle(0, 0, 0, 0, 0, 32'd15);
    chk("read_15", rd_data, 32'h0);
    cycle(0, 0, 0, 0, 0, 32'hFFFFFFFF);
    chk("read_ffffffff", rd_data, 32'h0);
    cycle(0, 0, 0, 0, 0, 32'd11);
    // reload from DONE with 3 words; higher words must survive
    cycle(0, 1, 3, 0, 0, 0);
    for (int i = 0; i < 3; i++) send_word($urandom, 32'($urandom_range(0, 12)), 1);
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 0, 0, 0, 32'(i));
    chk("reload_keep_10", rd_data, 32'h14C0FFFD);
    // reset after 6 bytes of a load
    cycle(0, 1, 4, 0, 0, 0);
    send_word(32'hDEADBEEF, 0, 1);
    cycle(0, 0, 0, 1, 8'h12, 0);
    cycle(0, 0, 0, 1, 8'h34, 0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("midload_idle", 32'(loading), 32'h0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("midload_read0", rd_data, 32'h0);
    chk("midload_wl", 32'(words_loaded), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 11, meaning number of 32-bit instruction words held.
REQ-002 SHALL have parameter AW, default 4, meaning width of word_count and words_loaded; 2^AW SHALL be >= DEPTH+1.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a program load.
REQ-006 SHALL have port word_count  input  AW  number of words to load, sampled only on an accepted start.
REQ-007 SHALL have port byte_in  input  8  program byte from the host.
REQ-008 SHALL have port byte_valid  input  1  byte_in holds a valid byte.
REQ-009 SHALL have port byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 SHALL have port rd_addr  input  32  word index from the fetch stage (PC).
REQ-011 SHALL have port rd_data  output  32  registered instruction word.
REQ-012 SHALL have port loading  output  1  high while in LOAD.
REQ-013 SHALL have port load_done  output  1  high while in DONE.
REQ-014 SHALL have port words_loaded  output  AW  words written in the current or last load.
REQ-015 SHALL have port err  output  1  sticky flag for an illegal word_count.

Function
REQ-016 SHALL implement a state machine with three states: IDLE, LOAD and DONE.
REQ-017 In IDLE or DONE, start with 1 <= word_count <= DEPTH SHALL move the FSM to LOAD, latch word_count, clear words_loaded, clear the byte index and clear err.
REQ-018 In IDLE or DONE, start with word_count = 0 or word_count > DEPTH SHALL set err and leave the state, memory and words_loaded unchanged.
REQ-019 start SHALL be ignored while in LOAD.
REQ-020 byte_ready SHALL equal 1 exactly when the state is LOAD; a byte is accepted on any edge where byte_valid and byte_ready are both 1.
REQ-021 Bytes SHALL be assembled big-endian: 1st accepted byte into [31:24], 2nd into [23:16], 3rd into [15:8], 4th into [7:0].
REQ-022 On the edge accepting the 4th byte, the full word SHALL be written to mem[words_loaded], words_loaded SHALL increment, and the byte index SHALL wrap to 0.
REQ-023 When the word written makes words_loaded equal the latched count, the FSM SHALL go to DONE on that same edge.
REQ-024 Idle gaps (byte_valid = 0) of any length SHALL NOT alter the partial word or the byte index.
REQ-025 rd_data SHALL take mem[rd_addr] on each rising edge (1-cycle latency) in every state; rd_addr >= DEPTH SHALL return 0.
REQ-026 A read and a write to the same address on the same edge SHALL return the old contents (read-before-write).
REQ-027 A reload from DONE SHALL overwrite words 0..count-1 and leave higher words unchanged.

Reset
REQ-028 reset SHALL take priority over all other inputs on the edge where it is sampled high.
REQ-029 On reset the FSM SHALL enter IDLE; byte_ready, loading, load_done and err SHALL be 0; words_loaded, the byte index and rd_data SHALL be 0.
REQ-030 On reset all DEPTH memory words SHALL be cleared to 0.
REQ-031 A reset during LOAD SHALL discard any partial word and every word already written.

Verification
REQ-032 After reset: start with word_count = 1, then bytes 8C 01 00 00 -> load_done = 1 on the edge of the 4th byte; rd_addr = 0 -> rd_data = 0x8C010000 one cycle later.
REQ-033 Full load: word_count = 11, 44 bytes that encode words 0x8C010000 .. 0x14C0FFFD, with random byte_valid gaps -> words_loaded = 11, load_done = 1, and each address 0..10 reads back its word.
REQ-034 Bad count: start with word_count = 12, then start with word_count = 0 -> err = 1, state stays IDLE, byte_ready = 0; a later valid start clears err.
REQ-035 Reset mid-load: reset after 6 bytes -> state IDLE, words_loaded = 0, rd_addr = 0 reads 0x00000000.
REQ-036 Boundary read: rd_addr = 15 and rd_addr = 0xFFFFFFFF -> rd_data = 0.
REQ-037 Read/write collision: rd_addr = 2 held during the write of word 2 = 0x24040000 -> old value returned that cycle and 0x24040000 the next cycle.
